// File: rtl/neander_control_if.sv
// Control-to-datapath bundle for the Neander sequencer: opcode/flags in,
// register enables, mux selects and debug state out.
interface neander_control_if;
  logic [3:0] opcode;
  logic       N;
  logic       Z;
  logic [1:0] selPC;
  logic       INST;
  logic       selREM;
  logic       loadREM;
  logic       loadRDM;
  logic       loadRI;
  logic       loadAC;
  logic       loadNZ;
  logic       memRead;
  logic       memWrite;
  logic [2:0] selULA;
  logic       halted;
  logic [3:0] state;

  modport slave (
    input  opcode, N, Z,
    output selPC, INST, selREM, loadREM, loadRDM, loadRI, loadAC, loadNZ,
           memRead, memWrite, selULA, halted, state
  );

  modport master (
    output opcode, N, Z,
    input  selPC, INST, selREM, loadREM, loadRDM, loadRI, loadAC, loadNZ,
           memRead, memWrite, selULA, halted, state
  );
endinterface

// File: rtl/neander_control.sv
// Neander instruction sequencer: fetch/decode/execute FSM driving the
// datapath enables combinationally from the state register.
//
// state | meaning
// S_RST | reset, clear PC
// S_T0  | REM <- PC (fetch)
// S_T1  | RDM <- mem[REM], PC++
// S_T2  | RI <- RDM
// S_T3  | decode; single-cycle ops, branch decision
// S_T4  | operand address fetch, PC++ for non-jumps
// S_T5  | jumps load PC; others REM <- RDM
// S_T6  | STA: RDM <- AC; others RDM <- mem[REM]
// S_T7  | STA write or AC/NZ update
// S_HLT | halted until reset
module neander_control (
  input  logic                 clock,
  input  logic                 nreset,
  neander_control_if.slave     bus
);

  typedef enum logic [3:0] {
    S_RST = 4'd0,
    S_T0  = 4'd1,
    S_T1  = 4'd2,
    S_T2  = 4'd3,
    S_T3  = 4'd4,
    S_T4  = 4'd5,
    S_T5  = 4'd6,
    S_T6  = 4'd7,
    S_T7  = 4'd8,
    S_HLT = 4'd9
  } state_t;

  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t r_state;
  state_t w_next;
  logic   w_is_jump;

  // Only taken jumps ever reach S_T4, so the opcode alone identifies them later
  assign w_is_jump = (bus.opcode == OP_JMP) || (bus.opcode == OP_JN) ||
                     (bus.opcode == OP_JZ);

  always_ff @(posedge clock) begin
    if (!nreset) r_state <= S_RST;
    else         r_state <= w_next;
  end

  assign bus.state = r_state;

  always_comb begin
    bus.selPC    = 2'b11;
    bus.INST     = 1'b0;
    bus.selREM   = 1'b0;
    bus.loadREM  = 1'b0;
    bus.loadRDM  = 1'b0;
    bus.loadRI   = 1'b0;
    bus.loadAC   = 1'b0;
    bus.loadNZ   = 1'b0;
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
    bus.selULA   = 3'b000;
    bus.halted   = 1'b0;
    w_next       = S_RST;

    case (r_state)
      S_RST: begin
        bus.selPC = 2'b10;
        w_next    = S_T0;
      end
      S_T0: begin
        bus.loadREM = 1'b1;
        bus.INST    = 1'b1;
        w_next      = S_T1;
      end
      S_T1: begin
        bus.memRead = 1'b1;
        bus.selPC   = 2'b01;
        bus.INST    = 1'b1;
        w_next      = S_T2;
      end
      S_T2: begin
        bus.loadRI = 1'b1;
        bus.INST   = 1'b1;
        w_next     = S_T3;
      end
      S_T3: begin
        case (bus.opcode)
          OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_JMP: begin
            bus.loadREM = 1'b1;
            w_next      = S_T4;
          end
          OP_NOT: begin
            bus.loadAC = 1'b1;
            bus.loadNZ = 1'b1;
            bus.selULA = 3'b011;
            w_next     = S_T0;
          end
          OP_JN, OP_JZ: begin
            if ((bus.opcode == OP_JN) ? bus.N : bus.Z) begin
              bus.loadREM = 1'b1;
              w_next      = S_T4;
            end else begin
              bus.selPC = 2'b01;
              w_next    = S_T0;
            end
          end
          OP_HLT:  w_next = S_HLT;
          default: w_next = S_T0;
        endcase
      end
      S_T4: begin
        bus.memRead = 1'b1;
        if (!w_is_jump) bus.selPC = 2'b01;
        w_next = S_T5;
      end
      S_T5: begin
        if (w_is_jump) begin
          bus.selPC = 2'b00;
          w_next    = S_T0;
        end else begin
          bus.selREM  = 1'b1;
          bus.loadREM = 1'b1;
          w_next      = S_T6;
        end
      end
      S_T6: begin
        if (bus.opcode == OP_STA) bus.loadRDM = 1'b1;
        else                      bus.memRead = 1'b1;
        w_next = S_T7;
      end
      S_T7: begin
        case (bus.opcode)
          OP_STA: bus.memWrite = 1'b1;
          OP_LDA: begin
            bus.loadAC = 1'b1;
            bus.loadNZ = 1'b1;
            bus.selULA = 3'b100;
          end
          OP_ADD: begin
            bus.loadAC = 1'b1;
            bus.loadNZ = 1'b1;
            bus.selULA = 3'b000;
          end
          OP_OR: begin
            bus.loadAC = 1'b1;
            bus.loadNZ = 1'b1;
            bus.selULA = 3'b010;
          end
          OP_AND: begin
            bus.loadAC = 1'b1;
            bus.loadNZ = 1'b1;
            bus.selULA = 3'b001;
          end
          default: ;
        endcase
        w_next = S_T0;
      end
      S_HLT: begin
        bus.halted = 1'b1;
        w_next     = S_HLT;
      end
      default: w_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_neander_control.sv
// Directed bench for neander_control: per-cycle vector table of states and
// output bundles, plus reset, halt and mid-instruction reset sequences.
module tb_neander_control;

  logic clock = 1'b0;
  logic nreset;
  int   n_pass  = 0;
  int   n_total = 0;

  neander_control_if bus ();

  neander_control dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, want summary");
    $fatal(1);
  end

  // Output vector: selPC(2) INST selREM loadREM loadRDM loadRI loadAC loadNZ memRead memWrite selULA(3) halted
  localparam logic [14:0] E_RST  = 15'b10_0_0_0_0_0_0_0_0_0_000_0;
  localparam logic [14:0] E_T0   = 15'b11_1_0_1_0_0_0_0_0_0_000_0;
  localparam logic [14:0] E_T1   = 15'b01_1_0_0_0_0_0_0_1_0_000_0;
  localparam logic [14:0] E_T2   = 15'b11_1_0_0_0_1_0_0_0_0_000_0;
  localparam logic [14:0] E_IDLE = 15'b11_0_0_0_0_0_0_0_0_0_000_0;
  localparam logic [14:0] E_NOT  = 15'b11_0_0_0_0_0_1_1_0_0_011_0;
  localparam logic [14:0] E_SKIP = 15'b01_0_0_0_0_0_0_0_0_0_000_0;
  localparam logic [14:0] E_T3GO = 15'b11_0_0_1_0_0_0_0_0_0_000_0;
  localparam logic [14:0] E_T4   = 15'b01_0_0_0_0_0_0_0_1_0_000_0;
  localparam logic [14:0] E_T4J  = 15'b11_0_0_0_0_0_0_0_1_0_000_0;
  localparam logic [14:0] E_T5J  = 15'b00_0_0_0_0_0_0_0_0_0_000_0;
  localparam logic [14:0] E_T5   = 15'b11_0_1_1_0_0_0_0_0_0_000_0;
  localparam logic [14:0] E_T6S  = 15'b11_0_0_0_1_0_0_0_0_0_000_0;
  localparam logic [14:0] E_T6   = 15'b11_0_0_0_0_0_0_0_1_0_000_0;
  localparam logic [14:0] E_T7S  = 15'b11_0_0_0_0_0_0_0_0_1_000_0;
  localparam logic [14:0] E_T7L  = 15'b11_0_0_0_0_0_1_1_0_0_100_0;
  localparam logic [14:0] E_T7A  = 15'b11_0_0_0_0_0_1_1_0_0_000_0;
  localparam logic [14:0] E_T7O  = 15'b11_0_0_0_0_0_1_1_0_0_010_0;
  localparam logic [14:0] E_T7N  = 15'b11_0_0_0_0_0_1_1_0_0_001_0;
  localparam logic [14:0] E_HLT  = 15'b11_0_0_0_0_0_0_0_0_0_000_1;

  typedef struct {
    logic [3:0]  op;
    logic        n;
    logic        z;
    logic [3:0]  st;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] outs();
    return {bus.selPC, bus.INST, bus.selREM, bus.loadREM, bus.loadRDM,
            bus.loadRI, bus.loadAC, bus.loadNZ, bus.memRead, bus.memWrite,
            bus.selULA, bus.halted};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic chk_cycle(input string name, input logic [3:0] st,
                           input logic [14:0] e);
    check({name, ".state"}, {28'd0, bus.state}, {28'd0, st});
    check({name, ".outs"}, {17'd0, outs()}, {17'd0, e});
  endtask

  task automatic add(input logic [3:0] op, input logic n, input logic z,
                     input logic [3:0] st, input logic [14:0] e);
    vecs.push_back('{op: op, n: n, z: z, st: st, exp: e});
  endtask

  task automatic fetch(input logic [3:0] op, input logic n, input logic z);
    add(op, n, z, 4'd1, E_T0);
    add(op, n, z, 4'd2, E_T1);
    add(op, n, z, 4'd3, E_T2);
  endtask

  task automatic short_instr(input logic [3:0] op, input logic n,
                             input logic z, input logic [14:0] e3);
    fetch(op, n, z);
    add(op, n, z, 4'd4, e3);
  endtask

  task automatic mem_instr(input logic [3:0] op, input logic [14:0] e6,
                           input logic [14:0] e7);
    fetch(op, 1'b0, 1'b0);
    add(op, 1'b0, 1'b0, 4'd4, E_T3GO);
    add(op, 1'b0, 1'b0, 4'd5, E_T4);
    add(op, 1'b0, 1'b0, 4'd6, E_T5);
    add(op, 1'b0, 1'b0, 4'd7, e6);
    add(op, 1'b0, 1'b0, 4'd8, e7);
  endtask

  // n_late/z_late are applied after decode; a taken jump must not notice them
  task automatic jump_taken(input logic [3:0] op, input logic n, input logic z,
                            input logic n_late, input logic z_late);
    fetch(op, n, z);
    add(op, n, z, 4'd4, E_T3GO);
    add(op, n_late, z_late, 4'd5, E_T4J);
    add(op, n_late, z_late, 4'd6, E_T5J);
  endtask

  initial begin
    nreset     = 1'b0;
    bus.opcode = 4'h0;
    bus.N      = 1'b0;
    bus.Z      = 1'b0;

    mem_instr(4'h2, E_T6, E_T7L);
    mem_instr(4'h3, E_T6, E_T7A);
    mem_instr(4'h4, E_T6, E_T7O);
    mem_instr(4'h5, E_T6, E_T7N);
    mem_instr(4'h1, E_T6S, E_T7S);
    short_instr(4'h0, 1'b1, 1'b1, E_IDLE);
    short_instr(4'h7, 1'b0, 1'b0, E_IDLE);
    short_instr(4'hC, 1'b1, 1'b0, E_IDLE);
    short_instr(4'h6, 1'b0, 1'b0, E_NOT);
    short_instr(4'h9, 1'b0, 1'b1, E_SKIP);
    short_instr(4'hA, 1'b1, 1'b0, E_SKIP);
    jump_taken(4'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    jump_taken(4'h9, 1'b1, 1'b0, 1'b1, 1'b0);
    jump_taken(4'hA, 1'b0, 1'b1, 1'b0, 1'b1);
    jump_taken(4'h9, 1'b1, 1'b0, 1'b0, 1'b0);
    jump_taken(4'hA, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset held for two edges, then release into fetch
    @(negedge clock);
    #1 chk_cycle("rst_hold1", 4'd0, E_RST);
    @(negedge clock);
    #1 chk_cycle("rst_hold2", 4'd0, E_RST);
    nreset = 1'b1;
    @(negedge clock);
    #1 chk_cycle("rst_rel_t0", 4'd1, E_T0);
    @(negedge clock);
    #1 chk_cycle("rst_rel_t1", 4'd2, E_T1);
    @(negedge clock);
    #1 chk_cycle("rst_rel_t2", 4'd3, E_T2);
    @(negedge clock);
    #1 chk_cycle("rst_rel_t3", 4'd4, E_IDLE);
    @(negedge clock);

    foreach (vecs[i]) begin
      bus.opcode = vecs[i].op;
      bus.N      = vecs[i].n;
      bus.Z      = vecs[i].z;
      #1 chk_cycle($sformatf("vec%0d_op%h", i, vecs[i].op), vecs[i].st,
                   vecs[i].exp);
      @(negedge clock);
    end

    bus.opcode = 4'hF;
    bus.N      = 1'b0;
    bus.Z      = 1'b0;
    #1 chk_cycle("hlt_t0", 4'd1, E_T0);
    @(negedge clock);
    #1 chk_cycle("hlt_t1", 4'd2, E_T1);
    @(negedge clock);
    #1 chk_cycle("hlt_t2", 4'd3, E_T2);
    @(negedge clock);
    #1 chk_cycle("hlt_t3", 4'd4, E_IDLE);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      #1 chk_cycle($sformatf("hlt_hold%0d", k), 4'd9, E_HLT);
    end
    nreset = 1'b0;
    @(negedge clock);
    #1 chk_cycle("hlt_rst", 4'd0, E_RST);
    nreset = 1'b1;
    @(negedge clock);
    #1 chk_cycle("hlt_rel", 4'd1, E_T0);

    // Reset landing in S_T6 of ADD must abort the data read and AC update
    bus.opcode = 4'h3;
    for (int k = 0; k < 10 && bus.state != 4'd7; k++) begin
      @(negedge clock);
      #1;
    end
    check("mid_reach_t6", {28'd0, bus.state}, 32'd7);
    nreset = 1'b0;
    @(negedge clock);
    #1 chk_cycle("mid_rst", 4'd0, E_RST);
    nreset = 1'b1;
    @(negedge clock);
    #1 chk_cycle("mid_rel", 4'd1, E_T0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/neander_control.md
NEANDER_CONTROL -- requirements
Module: neander_control

Interface
REQ-001 SHALL: clock  in  1  single system clock; all state changes on the rising edge.
REQ-002 SHALL: nreset  in  1  reset, synchronous and active-low.
REQ-003 SHALL: opcode  in  4  RI[7:4] from the instruction register.
REQ-004 SHALL: N, Z  in  1 each  registered AC flags.
REQ-005 SHALL: selPC  out  2  PC mux select: 00 load RDM, 01 increment, 10 clear to 0, 11 hold.
REQ-006 SHALL: INST  out  1  high during the fetch states S_T0..S_T2.
REQ-007 SHALL: selREM  out  1  REM source: 0 = PC, 1 = RDM.
REQ-008 SHALL: loadREM, loadRDM, loadRI, loadAC, loadNZ  out  1 each  register load enables, meaning "capture at this edge".
REQ-009 SHALL: memRead  out  1  RDM captures mem[REM] at this edge.
REQ-010 SHALL: memWrite  out  1  mem[REM] is written with RDM at this edge.
REQ-011 SHALL: selULA  out  3  ALU op: 000 ADD, 001 AND, 010 OR, 011 NOT, 100 pass Y.
REQ-012 SHALL: halted  out  1  high only in S_HLT.
REQ-013 SHALL: state  out  4  debug code: S_RST=0, S_T0..S_T7=1..8, S_HLT=9.

Function
REQ-014 SHALL: all outputs are Moore/Mealy-combinational from the state register and opcode/N/Z, with no output registers and a 1-cycle state step.
REQ-015 SHALL: in every state, any output not listed for that state is 0, except selPC, which defaults to 11 (hold).
REQ-016 SHALL: in S_RST, selPC=10; next state is S_T0.
REQ-017 SHALL: in S_T0, selREM=0, loadREM=1, INST=1; next state is S_T1.
REQ-018 SHALL: in S_T1, memRead=1, selPC=01, INST=1; next state is S_T2.
REQ-019 SHALL: in S_T2, loadRI=1, INST=1; next state is S_T3.
REQ-020 SHALL: S_T3 (decode) handles opcodes as follows:
  - 0x0 (NOP) and undefined opcodes 0x7, 0xB-0xE: go to S_T0.
  - 0x6 (NOT): loadAC=1, loadNZ=1, selULA=011; go to S_T0.
  - 0xF (HLT): go to S_HLT.
  - 0x9 (JN) with N=0, or 0xA (JZ) with Z=0: selPC=01 to skip the operand; go to S_T0.
  - All other opcodes (STA 1, LDA 2, ADD 3, OR 4, AND 5, JMP 8, taken JN/JZ): selREM=0, loadREM=1; go to S_T4.
REQ-021 SHALL: in S_T4, memRead=1; selPC=01 unless opcode is 8/9/A; next state is S_T5.
REQ-022 SHALL: in S_T5, opcode 8/9/A gives selPC=00 and next state S_T0; all others give selREM=1, loadREM=1, next state S_T6.
REQ-023 SHALL: in S_T6, STA gives loadRDM=1 (RDM<-AC); all others give memRead=1; next state is S_T7.
REQ-024 SHALL: in S_T7, STA gives memWrite=1; LDA/ADD/OR/AND give loadAC=1, loadNZ=1, with selULA 100/000/010/001 respectively; next state is S_T0.
REQ-025 SHALL: the branch decision is made only in S_T3; N/Z changes after S_T3 do not alter a jump in progress.
REQ-026 SHALL: S_HLT outputs halted=1, selPC=11, all enables 0, and remains in S_HLT until reset.
REQ-027 SHALL: instruction latencies are:
  - NOP/NOT/HLT/not-taken jump: 4 cycles.
  - JMP/taken jump: 6 cycles.
  - STA/LDA/ADD/OR/AND: 8 cycles.

Reset
REQ-028 SHALL: nreset=0 at an edge forces state to S_RST from any state, including mid-instruction and S_HLT.
REQ-029 SHALL: while nreset is held low, the block stays in S_RST, outputting selPC=10 and all enables 0.
REQ-030 SHALL: the first rising edge with nreset=1 moves the block to S_T0.

Verification
REQ-031 SHALL: reset test: hold nreset=0 for 2 cycles, then release -> state=0 with selPC=10 during reset, then state codes 1,2,3 on the following cycles with INST=1.
REQ-032 SHALL: LDA test: opcode=2 -> state sequence 1..8; selULA=100 and loadAC=loadNZ=1 in S_T7; 8 cycles between S_T0 visits.
REQ-033 SHALL: JN test, N=0: opcode=9 -> in S_T3, selPC=01 and next state=1. With N=1 -> S_T4 with selPC=11, then S_T5 with selPC=00.
REQ-034 SHALL: STA test: opcode=1 -> loadRDM=1 in S_T6, memWrite=1 in S_T7, loadAC=0 throughout.
REQ-035 SHALL: HLT test: opcode=F -> state=9 and halted=1 held for 20 cycles; nreset pulse -> state=0, then 1.
REQ-036 SHALL: mid-instruction reset: nreset=0 in S_T6 of ADD -> state=0 next cycle, with memRead=0 and loadAC=0.
